// File: rtl/alu_serial.sv
// Bit-serial 74382-style ALU: processes one ALU_W-bit slice per clock across a
// CHAIN_W-bit operand pair, with valid/ready handshakes on both sides.
module alu_serial #(
    parameter int CHAIN_W = 16,
    parameter int ALU_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         sel,
    input  logic               carry_in,
    input  logic [CHAIN_W-1:0] port_a,
    input  logic [CHAIN_W-1:0] port_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHAIN_W-1:0] result,
    output logic               overflow,
    output logic               carry_out
);

    localparam int N  = CHAIN_W / ALU_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (ALU_W < 1 || CHAIN_W < ALU_W || (CHAIN_W % ALU_W) != 0) begin : g_bad_params
            $error("alu_serial: CHAIN_W must be a nonzero multiple of ALU_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [2:0]         sel_reg;
    logic               carry_reg;
    logic [CHAIN_W-1:0] a_reg;
    logic [CHAIN_W-1:0] b_reg;
    logic [CHAIN_W-1:0] acc_reg;
    logic [CHAIN_W-1:0] result_reg;
    logic [CW-1:0]      cnt_reg;
    logic               overflow_reg;
    logic               carry_out_reg;

    logic               accept;
    logic               last_slice;

    // Slice datapath: operands always sit in the low slice of the shift registers
    logic [ALU_W-1:0]   slice_a, slice_b;
    logic [ALU_W-1:0]   op_a, op_b;
    logic [ALU_W-1:0]   slice_res;
    logic [ALU_W:0]     sum;
    logic               arith;
    logic               msb_cin;
    logic               slice_carry;
    logic               slice_ovf;
    logic [CHAIN_W-1:0] acc_next;

    assign slice_a = a_reg[ALU_W-1:0];
    assign slice_b = b_reg[ALU_W-1:0];

    always_comb begin
        op_a = slice_a;
        op_b = slice_b;
        case (sel_reg)
            3'b001:  op_a = ~slice_a;
            3'b010:  op_b = ~slice_b;
            default: ;
        endcase
    end

    assign sum   = {1'b0, op_a} + {1'b0, op_b} + {{ALU_W{1'b0}}, carry_reg};
    assign arith = (sel_reg == 3'b001) || (sel_reg == 3'b010) || (sel_reg == 3'b011);

    always_comb begin
        slice_res = sum[ALU_W-1:0];
        case (sel_reg)
            3'b000:  slice_res = '0;
            3'b100:  slice_res = slice_a ^ slice_b;
            3'b101:  slice_res = slice_a | slice_b;
            3'b110:  slice_res = slice_a & slice_b;
            3'b111:  slice_res = '1;
            default: slice_res = sum[ALU_W-1:0];
        endcase
    end

    // Carry into the MSB recovered from the MSB sum bit and its two operand bits
    assign msb_cin     = sum[ALU_W-1] ^ op_a[ALU_W-1] ^ op_b[ALU_W-1];
    assign slice_carry = arith & sum[ALU_W];
    assign slice_ovf   = arith & (msb_cin ^ sum[ALU_W]);

    generate
        if (N == 1) begin : g_single
            assign acc_next = slice_res;
        end else begin : g_multi
            assign acc_next = {slice_res, acc_reg[CHAIN_W-1:ALU_W]};
        end
    endgenerate

    assign last_slice = (cnt_reg == LAST);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
            carry_out_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                sel_reg   <= sel;
                carry_reg <= carry_in;
                a_reg     <= port_a;
                b_reg     <= port_b;
                cnt_reg   <= '0;
            end else if (state_reg == BUSY) begin
                a_reg     <= a_reg >> ALU_W;
                b_reg     <= b_reg >> ALU_W;
                carry_reg <= slice_carry;
                acc_reg   <= acc_next;
                if (last_slice) begin
                    cnt_reg       <= '0;
                    result_reg    <= acc_next;
                    overflow_reg  <= slice_ovf;
                    carry_out_reg <= slice_carry;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    end

    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign overflow  = overflow_reg;
    assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_alu_serial.sv
// Directed testbench for alu_serial (CHAIN_W=16, ALU_W=4): hand-computed
// results, handshake timing, backpressure and mid-operation reset.
module tb_alu_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic        carry_in;
    logic [15:0] port_a;
    logic [15:0] port_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        carry_out;

    int checks = 0;
    int errors = 0;

    alu_serial #(.CHAIN_W(16), .ALU_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .carry_in  (carry_in),
        .port_a    (port_a),
        .port_b    (port_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request and hold it until accepted; returns just after the accepting edge
    // with the operand pins scrambled so later changes must be ignored.
    task automatic start_op(input logic [2:0] s, input logic cin,
                            input logic [15:0] a, input logic [15:0] b);
        bit done;
        done = 0;
        @(negedge clk);
        in_valid = 1'b1;
        sel      = s;
        carry_in = cin;
        port_a   = a;
        port_b   = b;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        #1;
        in_valid = 1'b0;
        sel      = ~s;
        carry_in = ~cin;
        port_a   = ~a;
        port_b   = a ^ b ^ 16'h5A5A;
    endtask

    // Counts rising edges after acceptance until out_valid (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (out_valid) break;
        end
    endtask

    task automatic run_check(input string name, input logic [2:0] s, input logic cin,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp_r, input logic exp_co, input logic exp_ov);
        int cyc;
        start_op(s, cin, a, b);
        wait_done(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required 4", name, cyc);
        end
        checks++;
        if (result !== exp_r) begin
            errors++;
            $display("FAIL %s_result: got %h, required %h", name, result, exp_r);
        end
        checks++;
        if (carry_out !== exp_co) begin
            errors++;
            $display("FAIL %s_carry_out: got %b, required %b", name, carry_out, exp_co);
        end
        checks++;
        if (overflow !== exp_ov) begin
            errors++;
            $display("FAIL %s_overflow: got %b, required %b", name, overflow, exp_ov);
        end
        $display("op %s sel=%b cin=%b A=%h B=%h -> result=%h co=%b ov=%b (%0d cycles)",
                 name, s, cin, a, b, result, carry_out, overflow, cyc);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 3'b000;
        carry_in  = 1'b0;
        port_a    = '0;
        port_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (result !== 16'h0000 || overflow !== 1'b0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%h ov=%b co=%b, required 0000/0/0",
                     result, overflow, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        $display("reset: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
    endtask

    task automatic test_add();
        run_check("add_basic", 3'b011, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
        run_check("add_ovf",   3'b011, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        run_check("add_carry", 3'b011, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_check("add_cin",   3'b011, 1'b1, 16'h00FF, 16'h0100, 16'h0200, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        run_check("a_minus_b", 3'b010, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        run_check("b_minus_a", 3'b001, 1'b1, 16'h0005, 16'h0007, 16'h0002, 1'b1, 1'b0);
        run_check("sub_ovf",   3'b010, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    endtask

    task automatic test_logic();
        // carry_in=1 on logic ops must not leak into carry_out/overflow
        run_check("clear",  3'b000, 1'b1, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0);
        run_check("xor",    3'b100, 1'b1, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0);
        run_check("and",    3'b110, 1'b0, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0);
        run_check("or",     3'b101, 1'b0, 16'hA0A0, 16'h0505, 16'hA5A5, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(3'b011, 1'b0, 16'h0001, 16'h0002);
        out_ready = 1'b0;
        wait_done(cyc);
        @(negedge clk);
        in_valid = 1'b1;
        sel      = 3'b011;
        carry_in = 1'b0;
        port_a   = 16'h1111;
        port_b   = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 16'h0003 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: got out_valid=%b result=%h in_ready=%b, required 1/0003/0",
                         i, out_valid, result, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        port_a   = 16'hDEAD;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got out_valid=%b, required 0", out_valid);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 4 || result !== 16'h3333) begin
            errors++;
            $display("FAIL b2b_second: got %0d cycles result=%h, required 4 cycles 3333", cyc, result);
        end
        $display("back_to_back: second result=%h after %0d cycles", result, cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(3'b011, 1'b0, 16'h1234, 16'h0FFF);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got out_valid=%b result=%h in_ready=%b, required 0/0000/1",
                     out_valid, result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_dropped: got out_valid=%b, required 0", out_valid);
        end
        $display("mid_reset: out_valid=%b result=%h", out_valid, result);
        run_check("preset", 3'b111, 1'b1, 16'h1234, 16'h0FFF, 16'hFFFF, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
